lane_direction_fsm: RTL and testbench
=====================================

# lane_direction_fsm

Converts two debounced beam-break sensors at one parking lane (outer beam at the street side, inner beam at the lot side) into single-cycle entry and exit events for the downstream parking counters. The block also drives the lane barrier and flags stuck or aborted passages. One instance is placed per lane, normal and handicapped, between the debouncers and the corresponding parking counter.

## Interface
- TIMEOUT_CYCLES, 100_000_000 — max Sysclk cycles a passage may stay in any single tracking state (1 s at 100 MHz)
- Sysclk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- beam_outer  in  1  debounced outer sensor, 1 = blocked
- beam_inner  in  1  debounced inner sensor, 1 = blocked
- lot_full  in  1  level from counter, 1 = zero free slots
- entry_pulse  out  1  one-cycle pulse, completed entry
- exit_pulse  out  1  one-cycle pulse, completed exit
- gate_open  out  1  barrier open command
- fault  out  1  timeout or ambiguous passage; held until lane clears

## Operation
- Inputs are registered once into o_s and i_s. All decisions use o_s and i_s.
- States: IDLE, EN_O, EN_OI, EN_I, EX_I, EX_IO, EX_O, REJECT, WAIT_CLR.
- IDLE:
  - o_s=1, i_s=0: go to REJECT if lot_full, else EN_O.
  - o_s=0, i_s=1: go to EX_I.
  - Both 1: go to WAIT_CLR with fault.
- Entry path:
  - EN_O: o_s&i_s goes to EN_OI. Both 0 (backed out) goes to IDLE with no pulse.
  - EN_OI: o_s=0, i_s=1 goes to EN_I. o_s=1, i_s=0 goes back to EN_O. Both 0 goes to WAIT_CLR with fault.
  - EN_I: both 0 goes to IDLE and asserts entry_pulse. o_s=1 goes back to EN_OI.
- Exit path mirrors the entry path with the beams swapped. EX_O with both clear goes to IDLE and asserts exit_pulse.
- REJECT: barrier stays closed. Both clear goes to IDLE. No pulse.
- WAIT_CLR: waits for both beams 0, then goes to IDLE. fault=1 throughout.
- Timeout: a cycle counter of width $clog2(TIMEOUT_CYCLES+1) runs as follows.
  - Cleared on every state change and in IDLE and WAIT_CLR.
  - In any other state, reaching TIMEOUT_CYCLES-1 forces WAIT_CLR with fault.
- gate_open=1 in EN_O, EN_OI, EN_I, EX_I, EX_IO and EX_O. It is 0 otherwise.
- lot_full is only examined in IDLE. It going high mid-entry does not abort the entry.
- At most one of entry_pulse and exit_pulse is high in any cycle.

## Timing
- Reset values:
  - State is IDLE, o_s=i_s=0, timer=0.
  - entry_pulse=exit_pulse=gate_open=fault=0.
- All outputs are registered (Moore-decoded from next state, then flopped).
- Latency: a raw input change at edge k is sampled at edge k and acted on at edge k+1. The output is visible after edge k+1, i.e. the final beam clearing is followed by entry_pulse high for exactly the cycle after edge k+1.
- gate_open rises on the same edge the FSM enters EN_O or EX_I.
- Timeout fires on the edge where the counter equals TIMEOUT_CYCLES-1. fault rises that edge.
- Reset asserted mid-passage returns the block to IDLE on the next edge. No pulse is emitted, even if the passage would have completed that cycle.
- After reset, if beams are still blocked, normal IDLE decoding applies.

## Structure
- Shared package parking_pkg holds:
  - state encoding (localparam, 4 bits)
  - TIMEOUT_CYCLES default
  - SYSCLK_HZ
- One sub-module, lane_timeout_timer. Parameter N. Inputs: Sysclk, reset, clear, enable. Output: expired (level).
- FSM, input registers and output decode live in lane_direction_fsm.

## Test plan
All scenarios run with TIMEOUT_CYCLES=16.
- Clean entry: outer, outer+inner, inner, clear, 5 cycles each, lot_full=0. Expect one entry_pulse, 2 cycles after the final clear. gate_open high from EN_O to IDLE. fault=0.
- Clean exit: inner, inner+outer, outer, clear. Expect exactly one exit_pulse. entry_pulse never asserted.
- Back-out: outer, outer+inner, outer, clear. Expect no pulses, state IDLE, gate_open falls after the clear.
- Lot full: lot_full=1, then a full entry sequence. Expect gate_open=0 throughout and no entry_pulse. With lot_full=1, an exit sequence still yields exit_pulse.
- Timeout: hold outer only for 20 cycles. Expect fault=1 on cycle 16 after entering EN_O and gate_open=0. fault clears 2 cycles after outer drops. No pulse.
- Reset mid-passage: reset for 1 cycle while in EN_I. Expect all outputs 0 next cycle. A subsequent clear yields no entry_pulse.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared parking-lane definitions: FSM state encoding, clock rate, default timeout.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package parking_pkg;

    localparam int unsigned SYSCLK_HZ              = 100_000_000;
    // One second at SYSCLK_HZ: longest a vehicle may sit in one tracking state
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100_000_000;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_EN_O     = 4'd1;
    localparam logic [3:0] S_EN_OI    = 4'd2;
    localparam logic [3:0] S_EN_I     = 4'd3;
    localparam logic [3:0] S_EX_I     = 4'd4;
    localparam logic [3:0] S_EX_IO    = 4'd5;
    localparam logic [3:0] S_EX_O     = 4'd6;
    localparam logic [3:0] S_REJECT   = 4'd7;
    localparam logic [3:0] S_WAIT_CLR = 4'd8;

    // Barrier is open only while a vehicle is being tracked through the lane
    function automatic logic gate_state(input logic [3:0] s);
        return (s == S_EN_O) || (s == S_EN_OI) || (s == S_EN_I) ||
               (s == S_EX_I) || (s == S_EX_IO) || (s == S_EX_O);
    endfunction

    // States in which the passage timer is allowed to run
    function automatic logic timed_state(input logic [3:0] s);
        return (s != S_IDLE) && (s != S_WAIT_CLR);
    endfunction

endpackage

// File: rtl/lane_timeout_timer.sv
// Per-state dwell counter; expired is a level once the count reaches N-1.
// Latency: expired reflects the registered count (visible the cycle after the counting edge).
// Backpressure: none; saturates at N-1 until cleared.
module lane_timeout_timer #(
    parameter int unsigned N = 16
) (
    input  logic Sysclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(N + 1);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    // Count cycles spent in the current state; hold at LAST so it never wraps
    always_ff @(posedge Sysclk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/lane_direction_fsm.sv
// Turns outer/inner beam-break levels into entry/exit pulses, barrier control and fault.
// Latency: beam change sampled at edge k, acted on and outputs updated at edge k+1.
// Backpressure: none; sensor levels in, single-cycle pulses out, no flow control.
module lane_direction_fsm
    import parking_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic Sysclk,
    input  logic reset,
    input  logic beam_outer,
    input  logic beam_inner,
    input  logic lot_full,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic gate_open,
    output logic fault
);

    logic       o_s;
    logic       i_s;
    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       expired;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       entry_nxt;
    logic       exit_nxt;
    logic       gate_nxt;
    logic       fault_nxt;

    // Sample the debounced beams once; every decision below uses these copies
    always_ff @(posedge Sysclk) begin
        if (reset) begin
            o_s <= 1'b0;
            i_s <= 1'b0;
        end else begin
            o_s <= beam_outer;
            i_s <= beam_inner;
        end
    end

    // Passage tracking; a jump that skips the both-blocked phase is ambiguous and faults
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                case ({o_s, i_s})
                    2'b10:   state_nxt = lot_full ? S_REJECT : S_EN_O;
                    2'b01:   state_nxt = S_EX_I;
                    2'b11:   state_nxt = S_WAIT_CLR;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_EN_O: begin
                case ({o_s, i_s})
                    2'b11:   state_nxt = S_EN_OI;
                    2'b00:   state_nxt = S_IDLE;
                    2'b01:   state_nxt = S_WAIT_CLR;
                    default: state_nxt = S_EN_O;
                endcase
            end
            S_EN_OI: begin
                case ({o_s, i_s})
                    2'b01:   state_nxt = S_EN_I;
                    2'b10:   state_nxt = S_EN_O;
                    2'b00:   state_nxt = S_WAIT_CLR;
                    default: state_nxt = S_EN_OI;
                endcase
            end
            S_EN_I: begin
                if (o_s)       state_nxt = S_EN_OI;
                else if (!i_s) state_nxt = S_IDLE;
            end
            S_EX_I: begin
                case ({o_s, i_s})
                    2'b11:   state_nxt = S_EX_IO;
                    2'b00:   state_nxt = S_IDLE;
                    2'b10:   state_nxt = S_WAIT_CLR;
                    default: state_nxt = S_EX_I;
                endcase
            end
            S_EX_IO: begin
                case ({o_s, i_s})
                    2'b10:   state_nxt = S_EX_O;
                    2'b01:   state_nxt = S_EX_I;
                    2'b00:   state_nxt = S_WAIT_CLR;
                    default: state_nxt = S_EX_IO;
                endcase
            end
            S_EX_O: begin
                if (i_s)       state_nxt = S_EX_IO;
                else if (!o_s) state_nxt = S_IDLE;
            end
            S_REJECT: begin
                if (!o_s && !i_s) state_nxt = S_IDLE;
            end
            S_WAIT_CLR: begin
                if (!o_s && !i_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A stuck passage overrides whatever the beams say
        if (expired && timed_state(state)) begin
            state_nxt = S_WAIT_CLR;
        end
    end

    // Timer restarts on every state change and is held idle outside tracking states
    always_comb begin
        tmr_clear  = (state_nxt != state) || !timed_state(state);
        tmr_enable = timed_state(state);
    end

    lane_timeout_timer #(
        .N (TIMEOUT_CYCLES)
    ) u_timer (
        .Sysclk  (Sysclk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (expired)
    );

    // Output decode from the next state so registered outputs line up with the state flop
    always_comb begin
        entry_nxt = (state == S_EN_I) && (state_nxt == S_IDLE);
        exit_nxt  = (state == S_EX_O) && (state_nxt == S_IDLE);
        gate_nxt  = gate_state(state_nxt);
        fault_nxt = (state_nxt == S_WAIT_CLR);
    end

    // State and registered outputs; reset drops any passage without a pulse
    always_ff @(posedge Sysclk) begin
        if (reset) begin
            state       <= S_IDLE;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            gate_open   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_pulse <= entry_nxt;
            exit_pulse  <= exit_nxt;
            gate_open   <= gate_nxt;
            fault       <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_lane_direction_fsm.sv
// Directed bench for lane_direction_fsm with a 16-cycle passage timeout.
module tb_lane_direction_fsm;

    logic Sysclk = 1'b0;
    logic reset;
    logic beam_outer;
    logic beam_inner;
    logic lot_full;
    logic entry_pulse;
    logic exit_pulse;
    logic gate_open;
    logic fault;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_entry, n_exit, n_gate, n_fault, n_both;
    int last_entry, last_exit, first_gate, last_gate, first_fault;

    always #5 Sysclk = ~Sysclk;

    lane_direction_fsm #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Sysclk      (Sysclk),
        .reset       (reset),
        .beam_outer  (beam_outer),
        .beam_inner  (beam_inner),
        .lot_full    (lot_full),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .gate_open   (gate_open),
        .fault       (fault)
    );

    task automatic clr_stats();
        n_entry = 0; n_exit = 0; n_gate = 0; n_fault = 0; n_both = 0;
        last_entry = -1; last_exit = -1; first_gate = -1; last_gate = -1; first_fault = -1;
    endtask

    // One clock, then observe outputs 1 time unit after the edge
    task automatic tick();
        @(posedge Sysclk);
        #1;
        cyc++;
        if (entry_pulse) begin n_entry++; last_entry = cyc; end
        if (exit_pulse)  begin n_exit++;  last_exit  = cyc; end
        if (gate_open) begin
            n_gate++;
            last_gate = cyc;
            if (first_gate < 0) first_gate = cyc;
        end
        if (fault) begin
            n_fault++;
            if (first_fault < 0) first_fault = cyc;
        end
        if (entry_pulse && exit_pulse) n_both++;
    endtask

    task automatic run(input logic o, input logic i, input int n);
        beam_outer = o;
        beam_inner = i;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; beam_outer = 1'b0; beam_inner = 1'b0; lot_full = 1'b0;
        tick(); tick();
        total++; if (entry_pulse !== 1'b0) begin bad++; $display("FAIL reset_entry: got %b want 0", entry_pulse); end
        total++; if (exit_pulse  !== 1'b0) begin bad++; $display("FAIL reset_exit: got %b want 0", exit_pulse); end
        total++; if (gate_open   !== 1'b0) begin bad++; $display("FAIL reset_gate: got %b want 0", gate_open); end
        total++; if (fault       !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
        reset = 1'b0;
        run(0, 0, 3);
    endtask

    task automatic test_clean_entry();
        int start, cs;
        clr_stats(); lot_full = 1'b0; start = cyc;
        run(1, 0, 5); run(1, 1, 5); run(0, 1, 5);
        cs = cyc;
        run(0, 0, 5);
        total++; if (n_entry != 1) begin bad++; $display("FAIL entry_count: got %0d want 1", n_entry); end
        total++; if (last_entry != cs + 2) begin bad++; $display("FAIL entry_timing: got %0d want %0d", last_entry, cs + 2); end
        total++; if (n_exit != 0) begin bad++; $display("FAIL entry_no_exit: got %0d want 0", n_exit); end
        total++; if (first_gate != start + 2) begin bad++; $display("FAIL entry_gate_rise: got %0d want %0d", first_gate, start + 2); end
        total++; if (n_gate != 15) begin bad++; $display("FAIL entry_gate_cycles: got %0d want 15", n_gate); end
        total++; if (n_fault != 0) begin bad++; $display("FAIL entry_fault: got %0d want 0", n_fault); end
    endtask

    task automatic test_clean_exit();
        int cs;
        clr_stats(); lot_full = 1'b0;
        run(0, 1, 5); run(1, 1, 5); run(1, 0, 5);
        cs = cyc;
        run(0, 0, 5);
        total++; if (n_exit != 1) begin bad++; $display("FAIL exit_count: got %0d want 1", n_exit); end
        total++; if (last_exit != cs + 2) begin bad++; $display("FAIL exit_timing: got %0d want %0d", last_exit, cs + 2); end
        total++; if (n_entry != 0) begin bad++; $display("FAIL exit_no_entry: got %0d want 0", n_entry); end
        total++; if (n_gate != 15) begin bad++; $display("FAIL exit_gate_cycles: got %0d want 15", n_gate); end
        total++; if (n_both != 0) begin bad++; $display("FAIL exit_both_pulses: got %0d want 0", n_both); end
    endtask

    task automatic test_back_out();
        int cs;
        clr_stats(); lot_full = 1'b0;
        run(1, 0, 5); run(1, 1, 5); run(1, 0, 5);
        cs = cyc;
        run(0, 0, 5);
        total++; if (n_entry + n_exit != 0) begin bad++; $display("FAIL backout_pulses: got %0d want 0", n_entry + n_exit); end
        total++; if (last_gate != cs + 1) begin bad++; $display("FAIL backout_gate_fall: got %0d want %0d", last_gate, cs + 1); end
        total++; if (gate_open !== 1'b0) begin bad++; $display("FAIL backout_gate_end: got %b want 0", gate_open); end
        total++; if (n_fault != 0) begin bad++; $display("FAIL backout_fault: got %0d want 0", n_fault); end
    endtask

    task automatic test_lot_full();
        clr_stats(); lot_full = 1'b1;
        run(1, 0, 5); run(1, 1, 5); run(0, 1, 5); run(0, 0, 5);
        total++; if (n_gate != 0) begin bad++; $display("FAIL full_gate: got %0d want 0", n_gate); end
        total++; if (n_entry != 0) begin bad++; $display("FAIL full_entry: got %0d want 0", n_entry); end
        total++; if (n_fault != 0) begin bad++; $display("FAIL full_fault: got %0d want 0", n_fault); end
        clr_stats();
        run(0, 1, 5); run(1, 1, 5); run(1, 0, 5); run(0, 0, 5);
        total++; if (n_exit != 1) begin bad++; $display("FAIL full_exit: got %0d want 1", n_exit); end
        total++; if (n_gate != 15) begin bad++; $display("FAIL full_exit_gate: got %0d want 15", n_gate); end
        lot_full = 1'b0;
    endtask

    task automatic test_timeout();
        int start;
        clr_stats(); start = cyc;
        run(1, 0, 20);
        total++; if (first_fault != start + 18) begin bad++; $display("FAIL timeout_fault_rise: got %0d want %0d", first_fault, start + 18); end
        total++; if (n_gate != 16) begin bad++; $display("FAIL timeout_gate_cycles: got %0d want 16", n_gate); end
        total++; if (gate_open !== 1'b0) begin bad++; $display("FAIL timeout_gate: got %b want 0", gate_open); end
        beam_outer = 1'b0;
        tick();
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL timeout_fault_hold: got %b want 1", fault); end
        tick();
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL timeout_fault_clear: got %b want 0", fault); end
        run(0, 0, 3);
        total++; if (n_entry + n_exit != 0) begin bad++; $display("FAIL timeout_pulses: got %0d want 0", n_entry + n_exit); end
    endtask

    task automatic test_ambiguous();
        int start;
        clr_stats(); start = cyc;
        run(1, 1, 3);
        total++; if (first_fault != start + 2) begin bad++; $display("FAIL ambig_fault_rise: got %0d want %0d", first_fault, start + 2); end
        total++; if (n_gate != 0) begin bad++; $display("FAIL ambig_gate: got %0d want 0", n_gate); end
        run(0, 0, 4);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL ambig_fault_end: got %b want 0", fault); end
    endtask

    task automatic test_reset_mid_passage();
        clr_stats(); lot_full = 1'b0;
        run(1, 0, 5); run(1, 1, 5); run(0, 1, 5);
        total++; if (gate_open !== 1'b1) begin bad++; $display("FAIL midrst_gate_before: got %b want 1", gate_open); end
        // Clear now so the passage would complete on exactly the reset edge
        run(0, 0, 1);
        reset = 1'b1;
        tick();
        total++; if (entry_pulse !== 1'b0) begin bad++; $display("FAIL midrst_entry: got %b want 0", entry_pulse); end
        total++; if (exit_pulse  !== 1'b0) begin bad++; $display("FAIL midrst_exit: got %b want 0", exit_pulse); end
        total++; if (gate_open   !== 1'b0) begin bad++; $display("FAIL midrst_gate: got %b want 0", gate_open); end
        total++; if (fault       !== 1'b0) begin bad++; $display("FAIL midrst_fault: got %b want 0", fault); end
        reset = 1'b0;
        clr_stats();
        run(0, 0, 5);
        total++; if (n_entry != 0) begin bad++; $display("FAIL midrst_no_entry: got %0d want 0", n_entry); end
        total++; if (n_gate != 0) begin bad++; $display("FAIL midrst_no_gate: got %0d want 0", n_gate); end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_clean_entry();
        test_clean_exit();
        test_back_out();
        test_lot_full();
        test_timeout();
        test_ambiguous();
        test_reset_mid_passage();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
